// File: rtl/ddbb128_pkg.sv
// Shared FSM state type, configuration row numbers and config-address builder
// for the ddbb128 bus enumerator.
package ddbb128_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PROBE,
    SIZE_WR,
    SIZE_RD,
    CALC,
    ASSIGN_WR,
    IRQ_WR,
    CMD_WR,
    NEXT,
    FIN
  } state_e;

  localparam logic [4:0] ROW_ID  = 5'd0;
  localparam logic [4:0] ROW_BAR = 5'd1;
  localparam logic [4:0] ROW_IRQ = 5'd3;

  localparam logic [15:0] SEL_ALL = 16'hFFFF;
  localparam logic [15:0] SEL_BAR = 16'h0FFF;
  localparam logic [15:0] SEL_CMD = 16'h0300;
  localparam logic [15:0] SEL_IRQ = 16'h1000;

  // Layout: [27:20] bus, [19:15] device, [14:12] function 0, [8:4] row.
  function automatic logic [31:0] cfg_addr(input logic [7:0] bus,
                                           input logic [4:0] dev,
                                           input logic [4:0] row);
    return {4'h0, bus, dev, 3'b000, 3'b000, row, 4'h0};
  endfunction

endpackage

// File: rtl/ddbb128_enum_if.sv
// Configuration-space access bus: the enumerator is master, the device fabric
// is slave. One access is outstanding at a time.
interface ddbb128_enum_if;
  logic         cs_config_o;
  logic         we_o;
  logic [15:0]  sel_o;
  logic [31:0]  adr_o;
  logic [127:0] dat_o;
  logic         ack_i;
  logic [127:0] dat_i;

  modport master (
    output cs_config_o, we_o, sel_o, adr_o, dat_o,
    input  ack_i, dat_i
  );

  modport slave (
    input  cs_config_o, we_o, sel_o, adr_o, dat_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/ddbb128_bar_alloc.sv
// BAR placement: aligns the allocation pointer to a BAR's natural size and
// flags allocations that carry out of 32 bits or end past MEM_LIMIT.
module ddbb128_bar_alloc #(
  parameter logic [31:0] MEM_LIMIT = 32'h7FFF_FFFF
) (
  input  logic [31:0] mask,
  input  logic [31:0] ptr,
  output logic [31:0] base,
  output logic [31:0] new_ptr,
  output logic        ovf
);

  logic [32:0] aligned;
  logic [32:0] last;

  always_comb begin
    aligned = ({1'b0, ptr} + {1'b0, ~mask}) & {1'b1, mask};
    last    = {1'b0, aligned[31:0]} + {1'b0, ~mask};
    if (mask == 32'h0) begin
      // Unimplemented BAR: nothing to place, pointer untouched.
      base    = 32'h0;
      new_ptr = ptr;
      ovf     = 1'b0;
    end else begin
      base    = aligned[31:0];
      new_ptr = last[31:0] + 32'd1;
      ovf     = aligned[32] | last[32] | (last[31:0] > MEM_LIMIT);
    end
  end

endmodule

// File: rtl/ddbb128_enum.sv
// Configuration-space enumerator: probes devices 0..31 on CFG_BUS, sizes and
// assigns three memory BARs each, then writes the command word.
// Define DDBB128_ENUM_IRQ_EN to add a row-3 interrupt-line write per device.
module ddbb128_enum
  import ddbb128_pkg::*;
#(
  parameter logic [7:0]  CFG_BUS   = 8'd0,
  parameter logic [31:0] MEM_BASE  = 32'h4000_0000,
  parameter logic [31:0] MEM_LIMIT = 32'h7FFF_FFFF,
  parameter logic [15:0] TIMEOUT   = 16'd255,
  parameter logic [15:0] CMD_VALUE = 16'h0007
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [5:0]     dev_cnt_o,
  output logic [31:0]    next_base_o,
  ddbb128_enum_if.master bus
);

  state_e       state;
  logic [4:0]   dev;
  logic [15:0]  tmr;
  logic [1:0]   bar_idx;
  logic [31:0]  mask_q [3];
  logic [31:0]  base_q [3];

  logic         req_active;
  logic         req_we;
  logic [15:0]  req_sel;
  logic [4:0]   req_row;
  logic [127:0] req_dat;

  logic         acc_done;
  logic [127:0] acc_rdata;
  logic         vendor_absent;
  logic         unused_rd_hi;

  logic [31:0]  cur_mask;
  logic [31:0]  alloc_base;
  logic [31:0]  alloc_ptr;
  logic         alloc_ovf;

  // An access ends on ack_i or after TIMEOUT cycles; a timed-out read yields all-ones.
  assign acc_done      = bus.cs_config_o && (bus.ack_i || (tmr >= TIMEOUT - 16'd1));
  assign acc_rdata     = bus.ack_i ? bus.dat_i : {128{1'b1}};
  assign vendor_absent = (acc_rdata[15:0] == 16'hFFFF) || (acc_rdata[15:0] == 16'h0000);
  assign unused_rd_hi  = ^acc_rdata[127:96];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    req_active = 1'b1;
    req_we     = 1'b0;
    req_sel    = SEL_ALL;
    req_row    = ROW_ID;
    req_dat    = '0;
    case (state)
      PROBE: ;
      SIZE_WR: begin
        req_we         = 1'b1;
        req_row        = ROW_BAR;
        req_sel        = SEL_BAR;
        req_dat[95:0]  = {96{1'b1}};
      end
      SIZE_RD: begin
        req_row = ROW_BAR;
        req_sel = SEL_BAR;
      end
      ASSIGN_WR: begin
        req_we         = 1'b1;
        req_row        = ROW_BAR;
        req_sel        = SEL_BAR;
        req_dat[95:0]  = {base_q[2], base_q[1], base_q[0]};
      end
      IRQ_WR: begin
        req_we          = 1'b1;
        req_row         = ROW_IRQ;
        req_sel         = SEL_IRQ;
        req_dat[103:96] = {3'b000, dev};
      end
      CMD_WR: begin
        req_we        = 1'b1;
        req_row       = ROW_ID;
        req_sel       = SEL_CMD;
        req_dat[15:0] = CMD_VALUE;
      end
      default: req_active = 1'b0;
    endcase
  end

  always_comb begin
    case (bar_idx)
      2'd1:    cur_mask = mask_q[1];
      2'd2:    cur_mask = mask_q[2];
      default: cur_mask = mask_q[0];
    endcase
  end

  ddbb128_bar_alloc #(
    .MEM_LIMIT (MEM_LIMIT)
  ) u_bar_alloc (
    .mask    (cur_mask),
    .ptr     (next_base_o),
    .base    (alloc_base),
    .new_ptr (alloc_ptr),
    .ovf     (alloc_ovf)
  );

  // NOTE: mask/base scratch is always written before it is read in a pass, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (state == SIZE_RD && acc_done) begin
      mask_q[0] <= acc_rdata[31:0];
      mask_q[1] <= acc_rdata[63:32];
      mask_q[2] <= acc_rdata[95:64];
    end
    if (state == CALC && !alloc_ovf) begin
      for (int i = 0; i < 3; i++) begin
        if (bar_idx == 2'(i)) base_q[i] <= alloc_base;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst_i) begin
      state           <= IDLE;
      dev             <= '0;
      tmr             <= '0;
      bar_idx         <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      dev_cnt_o       <= '0;
      next_base_o     <= MEM_BASE;
      bus.cs_config_o <= 1'b0;
      bus.we_o        <= 1'b0;
      bus.sel_o       <= '0;
      bus.adr_o       <= '0;
      bus.dat_o       <= '0;
    end else begin
      done_o <= 1'b0;

      // Bus request is launched on the first cycle of an access state and held until it ends.
      if (req_active) begin
        if (!bus.cs_config_o) begin
          bus.cs_config_o <= 1'b1;
          bus.we_o        <= req_we;
          bus.sel_o       <= req_sel;
          bus.adr_o       <= cfg_addr(CFG_BUS, dev, req_row);
          bus.dat_o       <= req_dat;
          tmr             <= '0;
        end else if (acc_done) begin
          bus.cs_config_o <= 1'b0;
          bus.we_o        <= 1'b0;
          bus.sel_o       <= '0;
          bus.adr_o       <= '0;
          bus.dat_o       <= '0;
        end else begin
          tmr <= tmr + 16'd1;
        end
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            dev         <= '0;
            next_base_o <= MEM_BASE;
            dev_cnt_o   <= '0;
            err_o       <= 1'b0;
            busy_o      <= 1'b1;
            state       <= PROBE;
          end
        end
        PROBE:   if (acc_done) state <= vendor_absent ? NEXT : SIZE_WR;
        SIZE_WR: if (acc_done) state <= SIZE_RD;
        SIZE_RD: begin
          if (acc_done) begin
            bar_idx <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (alloc_ovf) begin
            err_o  <= 1'b1;
            done_o <= 1'b1;
            state  <= FIN;
          end else begin
            next_base_o <= alloc_ptr;
            if (bar_idx == 2'd2) state <= ASSIGN_WR;
            else                 bar_idx <= bar_idx + 2'd1;
          end
        end
        ASSIGN_WR: begin
          if (acc_done) begin
`ifdef DDBB128_ENUM_IRQ_EN
            state <= IRQ_WR;
`else
            state <= CMD_WR;
`endif
          end
        end
        IRQ_WR: if (acc_done) state <= CMD_WR;
        CMD_WR: begin
          if (acc_done) begin
            dev_cnt_o <= dev_cnt_o + 6'd1;
            state     <= NEXT;
          end
        end
        NEXT: begin
          if (dev == 5'd31) begin
            done_o <= 1'b1;
            state  <= FIN;
          end else begin
            dev   <= dev + 5'd1;
            state <= PROBE;
          end
        end
        FIN: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddbb128_enum.sv
// Directed bench for ddbb128_enum: three instances (default, misaligned base,
// tight limit) driven by one behavioural config-space responder.
module tb_ddbb128_enum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start     [3];
  logic         busy      [3];
  logic         done      [3];
  logic         err       [3];
  logic [5:0]   dev_cnt   [3];
  logic [31:0]  next_base [3];
  logic         cs        [3];
  logic         we        [3];
  logic [15:0]  sel       [3];
  logic [31:0]  adr       [3];
  logic [127:0] dato      [3];
  logic         ack       [3];
  logic [127:0] rdat      [3];

  ddbb128_enum_if bus0 ();
  ddbb128_enum_if bus1 ();
  ddbb128_enum_if bus2 ();

  ddbb128_enum u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
    .err_o(err[0]), .dev_cnt_o(dev_cnt[0]), .next_base_o(next_base[0]), .bus(bus0)
  );
  ddbb128_enum #(.MEM_BASE(32'h4000_0800)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
    .err_o(err[1]), .dev_cnt_o(dev_cnt[1]), .next_base_o(next_base[1]), .bus(bus1)
  );
  ddbb128_enum #(.MEM_LIMIT(32'h4000_FFFF)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .busy_o(busy[2]), .done_o(done[2]),
    .err_o(err[2]), .dev_cnt_o(dev_cnt[2]), .next_base_o(next_base[2]), .bus(bus2)
  );

  assign bus0.ack_i = ack[0];  assign bus0.dat_i = rdat[0];
  assign bus1.ack_i = ack[1];  assign bus1.dat_i = rdat[1];
  assign bus2.ack_i = ack[2];  assign bus2.dat_i = rdat[2];
  assign cs[0] = bus0.cs_config_o;  assign cs[1] = bus1.cs_config_o;  assign cs[2] = bus2.cs_config_o;
  assign we[0] = bus0.we_o;         assign we[1] = bus1.we_o;         assign we[2] = bus2.we_o;
  assign sel[0] = bus0.sel_o;       assign sel[1] = bus1.sel_o;       assign sel[2] = bus2.sel_o;
  assign adr[0] = bus0.adr_o;       assign adr[1] = bus1.adr_o;       assign adr[2] = bus2.adr_o;
  assign dato[0] = bus0.dat_o;      assign dato[1] = bus1.dat_o;      assign dato[2] = bus2.dat_o;

  // Device table shared by all responders.
  logic [31:0] present;
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [31:0] m2 [32];
  bit          ack_en;
  bit          stall_bar;
  bit          force_ack;

  // Responder log, per instance.
  logic [127:0] wr_row0 [3][32];
  logic [127:0] wr_row1 [3][32];
  logic [127:0] wr_row3 [3][32];
  logic [15:0]  sel_row0 [3][32];
  logic [15:0]  sel_row3 [3][32];
  int           n_row0 [3];
  int           n_row1 [3];
  int           n_row3 [3];
  int           n_probe [3];
  logic         cs_q [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Absent devices answer 16'h0000 (odd) or 16'hFFFF (even) so both absent codes get used.
  function automatic logic [127:0] read_model(input logic [4:0] d, input logic [4:0] r);
    logic [127:0] v;
    v = '0;
    if (r == 5'd0) begin
      if (present[d])  v[31:0] = 32'h0001_10EE;
      else if (d[0])   v = {128{1'b0}};
      else             v = {128{1'b1}};
    end else if (r == 5'd1) begin
      v[95:0] = {m2[d], m1[d], m0[d]};
    end
    return v;
  endfunction

  always @(negedge clk) begin
    logic [4:0] d;
    logic [4:0] r;
    for (int k = 0; k < 3; k++) begin
      d = adr[k][19:15];
      r = adr[k][8:4];
      if (start[k]) begin
        n_row0[k] = 0; n_row1[k] = 0; n_row3[k] = 0; n_probe[k] = 0;
      end
      if (cs[k] && !cs_q[k] && !we[k] && r == 5'd0) n_probe[k]++;
      cs_q[k] = cs[k];
      if (ack[k]) begin
        ack[k] = 1'b0;
      end else if (force_ack) begin
        ack[k] = 1'b1;
      end else if (cs[k] && ack_en && !(stall_bar && !we[k] && r == 5'd1)) begin
        ack[k] = 1'b1;
        if (r == 5'd3) n_row3[k]++;
        if (we[k]) begin
          case (r)
            5'd0: begin wr_row0[k][d] = dato[k]; sel_row0[k][d] = sel[k]; n_row0[k]++; end
            5'd1: begin wr_row1[k][d] = dato[k]; n_row1[k]++; end
            5'd3: begin wr_row3[k][d] = dato[k]; sel_row3[k][d] = sel[k]; end
            default: ;
          endcase
        end else begin
          rdat[k] = read_model(d, r);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_table();
    present = '0;
    for (int i = 0; i < 32; i++) begin
      m0[i] = '0; m1[i] = '0; m2[i] = '0;
    end
  endtask

  task automatic run_pass(input int k, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    start[k] = 1'b1;
    tick(1);
    start[k] = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      seen = done[k];
    end
    check({tag, " done pulse"}, seen, 1'b1);
    check({tag, " busy during FIN"}, busy[k], 1'b1);
    tick(1);
    check({tag, " done one cycle"}, done[k], 1'b0);
    check({tag, " busy cleared"}, busy[k], 1'b0);
  endtask

  initial begin
    bit d1, d2, found, any_busy, any_cs, any_done;
    rst = 1'b1;
    ack_en = 1'b1; stall_bar = 1'b0; force_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; ack[k] = 1'b0; rdat[k] = '0; cs_q[k] = 1'b0;
      n_row0[k] = 0; n_row1[k] = 0; n_row3[k] = 0; n_probe[k] = 0;
    end
    clear_table();
    tick(3);

    // Reset state
    check("rst busy", busy[0], 1'b0);
    check("rst done", done[0], 1'b0);
    check("rst err", err[0], 1'b0);
    check("rst dev_cnt", dev_cnt[0], 6'd0);
    check("rst cs", cs[0], 1'b0);
    check("rst adr", adr[0], 32'h0);
    check("rst next_base", next_base[0], 32'h4000_0000);
    check("rst next_base mis", next_base[1], 32'h4000_0800);
    rst = 1'b0;
    tick(2);

    // No devices at all: every probe times out
    ack_en = 1'b0;
    run_pass(0, 10000, "empty");
    check("empty probes", n_probe[0], 32);
    check("empty dev_cnt", dev_cnt[0], 6'd0);
    check("empty next_base", next_base[0], 32'h4000_0000);
    check("empty err", err[0], 1'b0);
    ack_en = 1'b1;

    // Device 3 with BAR masks FFFF0000 / unimplemented / FFFFF000
    clear_table();
    present[3] = 1'b1;
    m0[3] = 32'hFFFF_0000; m2[3] = 32'hFFFF_F000;
    run_pass(0, 2000, "dev3");
    check("dev3 dev_cnt", dev_cnt[0], 6'd1);
    check("dev3 next_base", next_base[0], 32'h4001_1000);
    check("dev3 bar writes", n_row1[0], 2);
    check("dev3 assign data", wr_row1[0][3], 128'h0000_0000_4001_0000_0000_0000_4000_0000);
    check("dev3 cmd data", wr_row0[0][3], 128'h7);
    check("dev3 cmd sel", sel_row0[0][3], 16'h0300);
    check("dev3 cmd count", n_row0[0], 1);
    check("dev3 err", err[0], 1'b0);

    // Device 5: interrupt-line write only in the IRQ build
    clear_table();
    present[5] = 1'b1;
    m0[5] = 32'hFFFF_F000;
    run_pass(0, 2000, "dev5");
    check("dev5 dev_cnt", dev_cnt[0], 6'd1);
    check("dev5 assign data", wr_row1[0][5], 128'h0000_0000_0000_0000_0000_0000_4000_0000);
`ifdef DDBB128_ENUM_IRQ_EN
    check("dev5 row3 count", n_row3[0], 1);
    check("dev5 irq line", wr_row3[0][5][103:96], 8'd5);
    check("dev5 irq sel", sel_row3[0][5], 16'h1000);
`else
    check("dev5 no row3", n_row3[0], 0);
`endif

    // Misaligned base (inst 1) and tight limit (inst 2) run side by side
    clear_table();
    present[2:0] = 3'b111;
    m0[0] = 32'hFFFF_F000; m0[1] = 32'hFFFF_F000; m0[2] = 32'hFFFE_0000;
    start[1] = 1'b1; start[2] = 1'b1;
    tick(1);
    start[1] = 1'b0; start[2] = 1'b0;
    d1 = 1'b0; d2 = 1'b0;
    for (int i = 0; i < 2000 && !(d1 && d2); i++) begin
      tick(1);
      d1 = d1 | done[1];
      d2 = d2 | done[2];
    end
    check("mis done", d1, 1'b1);
    check("mis dev0 base", wr_row1[1][0], 128'h0000_0000_0000_0000_0000_0000_4000_1000);
    check("mis dev1 base", wr_row1[1][1], 128'h0000_0000_0000_0000_0000_0000_4000_2000);
    check("mis dev2 base", wr_row1[1][2], 128'h0000_0000_0000_0000_0000_0000_4002_0000);
    check("mis dev_cnt", dev_cnt[1], 6'd3);
    check("mis next_base", next_base[1], 32'h4004_0000);
    check("mis err", err[1], 1'b0);
    check("lim done", d2, 1'b1);
    check("lim err", err[2], 1'b1);
    check("lim dev_cnt", dev_cnt[2], 6'd2);
    check("lim next_base", next_base[2], 32'h4000_2000);
    check("lim bar writes", n_row1[2], 5);
    check("lim cmd writes", n_row0[2], 2);
    check("lim dev2 no assign", wr_row1[2][2], 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    tick(2);
    check("lim err held", err[2], 1'b1);

    // Reset while the size read is waiting for ack
    clear_table();
    present[0] = 1'b1;
    m0[0] = 32'hFFFF_F000;
    stall_bar = 1'b1;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      found = cs[0] && !we[0] && (adr[0][8:4] == 5'd1);
    end
    check("rst-mid reached size read", found, 1'b1);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst-mid cs", cs[0], 1'b0);
    check("rst-mid busy", busy[0], 1'b0);
    check("rst-mid next_base", next_base[0], 32'h4000_0000);
    check("rst-mid dev_cnt", dev_cnt[0], 6'd0);
    rst = 1'b0;
    stall_bar = 1'b0;
    force_ack = 1'b1;
    any_busy = 1'b0; any_cs = 1'b0; any_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      any_busy = any_busy | busy[0];
      any_cs   = any_cs | cs[0];
      any_done = any_done | done[0];
    end
    force_ack = 1'b0;
    check("late ack busy", any_busy, 1'b0);
    check("late ack cs", any_cs, 1'b0);
    check("late ack done", any_done, 1'b0);
    check("late ack dev_cnt", dev_cnt[0], 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
